win_mon8: RTL and testbench

- Windowed threshold monitor placed directly downstream of the 8-bit unsigned magnitude compare stage.
- Each valid 8-bit sample is classified against programmable low and high thresholds as ABOVE, BELOW or INSIDE.
- A debounced FSM raises or clears a sticky high or low alarm from that classification.
- It counts alarm events and reports the current zone for status and interrupt logic.

---
 rtl/win_mon8_if.sv | 28 ++
 rtl/win_mon8.sv | 143 ++++++++++++++
 tb/tb_win_mon8.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/win_mon8_if.sv
// Sample/threshold bus and status outputs of the win_mon8 window monitor.
// The master drives samples and configuration; the slave is the monitor.
interface win_mon8_if #(
  parameter int CNT_W = 8
);
  logic             thr_ld;
  logic [7:0]       hi_thr;
  logic [7:0]       lo_thr;
  logic             s_valid;
  logic [7:0]       s_data;
  logic             clr;
  logic [1:0]       zone;
  logic             alarm_hi;
  logic             alarm_lo;
  logic             evt_pulse;
  logic [CNT_W-1:0] evt_cnt;
  logic             cfg_err;

  modport master (
    output thr_ld, hi_thr, lo_thr, s_valid, s_data, clr,
    input  zone, alarm_hi, alarm_lo, evt_pulse, evt_cnt, cfg_err
  );

  modport slave (
    input  thr_ld, hi_thr, lo_thr, s_valid, s_data, clr,
    output zone, alarm_hi, alarm_lo, evt_pulse, evt_cnt, cfg_err
  );
endinterface

// File: rtl/win_mon8.sv
// Windowed threshold monitor: classifies 8-bit samples against lo/hi thresholds
// and drives debounced sticky high/low alarms with a saturating event counter.
module win_mon8 #(
  parameter int DEB   = 3,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  win_mon8_if.slave  bus
);

  localparam logic [1:0] Z_INSIDE = 2'b00;
  localparam logic [1:0] Z_BELOW  = 2'b01;
  localparam logic [1:0] Z_ABOVE  = 2'b10;

  localparam logic [2:0] S_NORM    = 3'd0;
  localparam logic [2:0] S_PEND_HI = 3'd1;
  localparam logic [2:0] S_ALM_HI  = 3'd2;
  localparam logic [2:0] S_PEND_LO = 3'd3;
  localparam logic [2:0] S_ALM_LO  = 3'd4;

  localparam logic [3:0] DEB_V = 4'(DEB);

  logic [7:0]       hi_r, lo_r;
  logic [2:0]       st, st_nx;
  logic [3:0]       dcnt, cnt_nx, inc, cnt_up;
  logic [1:0]       cls, zone_r;
  logic             entry;
  logic             evt_pulse_r, cfg_err_r;
  logic [CNT_W-1:0] evt_cnt_r;

  // Thresholds are the registered copies, so a same-cycle load sees the old pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cls = Z_INSIDE;
    if (bus.s_data > hi_r)      cls = Z_ABOVE;
    else if (bus.s_data < lo_r) cls = Z_BELOW;
  end

  assign inc = dcnt + 4'd1;

  always_comb begin
    st_nx  = st;
    cnt_nx = dcnt;
    cnt_up = 4'd0;
    entry  = 1'b0;
    if (bus.s_valid) begin
      case (st)
        // NORM and both pending states share one rule: a qualifying sample
        // advances its own side or restarts at 1 on the other side.
        S_NORM, S_PEND_HI, S_PEND_LO: begin
          if (cls == Z_ABOVE) begin
            cnt_up = (st == S_PEND_HI) ? inc : 4'd1;
            if (cnt_up >= DEB_V) begin
              st_nx  = S_ALM_HI;
              cnt_nx = 4'd0;
              entry  = 1'b1;
            end else begin
              st_nx  = S_PEND_HI;
              cnt_nx = cnt_up;
            end
          end else if (cls == Z_BELOW) begin
            cnt_up = (st == S_PEND_LO) ? inc : 4'd1;
            if (cnt_up >= DEB_V) begin
              st_nx  = S_ALM_LO;
              cnt_nx = 4'd0;
              entry  = 1'b1;
            end else begin
              st_nx  = S_PEND_LO;
              cnt_nx = cnt_up;
            end
          end else begin
            st_nx  = S_NORM;
            cnt_nx = 4'd0;
          end
        end
        // In an alarm, any sample not on the alarm side is exit progress only.
        S_ALM_HI: begin
          if (cls == Z_ABOVE) begin
            cnt_nx = 4'd0;
          end else if (inc >= DEB_V) begin
            st_nx  = S_NORM;
            cnt_nx = 4'd0;
          end else begin
            cnt_nx = inc;
          end
        end
        S_ALM_LO: begin
          if (cls == Z_BELOW) begin
            cnt_nx = 4'd0;
          end else if (inc >= DEB_V) begin
            st_nx  = S_NORM;
            cnt_nx = 4'd0;
          end else begin
            cnt_nx = inc;
          end
        end
        default: begin
          st_nx  = S_NORM;
          cnt_nx = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r        <= 8'hFF;
      lo_r        <= 8'h00;
      cfg_err_r   <= 1'b0;
      st          <= S_NORM;
      dcnt        <= 4'd0;
      zone_r      <= Z_INSIDE;
      evt_pulse_r <= 1'b0;
      evt_cnt_r   <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      cfg_err_r <= 1'b0;
      if (bus.thr_ld) begin
        if (bus.lo_thr <= bus.hi_thr) begin
          hi_r <= bus.hi_thr;
          lo_r <= bus.lo_thr;
        end else begin
          cfg_err_r <= 1'b1;
        end
      end
      st          <= st_nx;
      dcnt        <= cnt_nx;
      evt_pulse_r <= entry;
      if (bus.s_valid) zone_r <= cls;
      if (bus.clr)                       evt_cnt_r <= '0;
      else if (entry && !(&evt_cnt_r))   evt_cnt_r <= evt_cnt_r + 1'b1;
    end
  end

  assign bus.zone      = zone_r;
  assign bus.alarm_hi  = (st == S_ALM_HI);
  assign bus.alarm_lo  = (st == S_ALM_LO);
  assign bus.evt_pulse = evt_pulse_r;
  assign bus.evt_cnt   = evt_cnt_r;
  assign bus.cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_win_mon8.sv
// Scoreboard bench for win_mon8: directed samples push hand-computed expected
// outputs into a queue; a monitor pops and compares after each clock edge.
module tb_win_mon8;

  localparam logic [1:0] ZI = 2'b00;
  localparam logic [1:0] ZB = 2'b01;
  localparam logic [1:0] ZA = 2'b10;

  typedef struct packed {
    logic [1:0] zone;
    logic       ahi;
    logic       alo;
    logic       pulse;
    logic [7:0] cnt;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  exp_t exp_q[$];

  win_mon8_if #(.CNT_W(8)) bus ();

  win_mon8 #(.DEB(3), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t actual();
    exp_t a;
    a.zone  = bus.zone;
    a.ahi   = bus.alarm_hi;
    a.alo   = bus.alarm_lo;
    a.pulse = bus.evt_pulse;
    a.cnt   = bus.evt_cnt;
    a.err   = bus.cfg_err;
    return a;
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got zone=%b hi=%b lo=%b pulse=%b cnt=%0d err=%b, expected zone=%b hi=%b lo=%b pulse=%b cnt=%0d err=%b",
               name, got.zone, got.ahi, got.alo, got.pulse, got.cnt, got.err,
               want.zone, want.ahi, want.alo, want.pulse, want.cnt, want.err);
    end
  endtask

  // Monitor: one expected record per driven cycle, checked just after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) check($sformatf("cycle%0d", cyc), actual(), exp_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step(input logic ld, input logic [7:0] hi, input logic [7:0] lo,
                      input logic v, input logic [7:0] d, input logic c,
                      input logic [1:0] ez, input logic eah, input logic eal,
                      input logic ep, input logic [7:0] ec, input logic ee);
    exp_t e;
    @(negedge clk);
    bus.thr_ld  = ld;
    bus.hi_thr  = hi;
    bus.lo_thr  = lo;
    bus.s_valid = v;
    bus.s_data  = d;
    bus.clr     = c;
    e.zone = ez; e.ahi = eah; e.alo = eal; e.pulse = ep; e.cnt = ec; e.err = ee;
    exp_q.push_back(e);
  endtask

  task automatic samp(input logic [7:0] d, input logic [1:0] ez, input logic eah,
                      input logic eal, input logic ep, input logic [7:0] ec);
    step(1'b0, 8'd0, 8'd0, 1'b1, d, 1'b0, ez, eah, eal, ep, ec, 1'b0);
  endtask

  task automatic idle(input logic [1:0] ez, input logic eah, input logic eal, input logic [7:0] ec);
    step(1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 1'b0, ez, eah, eal, 1'b0, ec, 1'b0);
  endtask

  initial begin
    exp_t zero;
    int   c;
    zero = '0;
    bus.thr_ld = 0; bus.hi_thr = 0; bus.lo_thr = 0;
    bus.s_valid = 0; bus.s_data = 0; bus.clr = 0;
    #3;
    check("reset_state", actual(), zero);
    @(negedge clk);
    rst_n = 1'b1;

    // Load lo=40 hi=200
    step(1'b1, 8'd200, 8'd40, 1'b0, 8'd0, 1'b0, ZI, 0, 0, 0, 8'd0, 0);

    // Three ABOVE samples raise alarm_hi
    samp(8'd201, ZA, 0, 0, 0, 8'd0);
    samp(8'd201, ZA, 0, 0, 0, 8'd0);
    samp(8'd201, ZA, 1, 0, 1, 8'd1);
    idle(ZA, 1, 0, 8'd1);

    // Exit ALM_HI with 100,20,20; BELOW does not start PEND_LO
    samp(8'd100, ZI, 1, 0, 0, 8'd1);
    samp(8'd20,  ZB, 1, 0, 0, 8'd1);
    samp(8'd20,  ZB, 0, 0, 0, 8'd1);
    samp(8'd20,  ZB, 0, 0, 0, 8'd1);
    samp(8'd20,  ZB, 0, 0, 0, 8'd1);
    samp(8'd20,  ZB, 0, 1, 1, 8'd2);
    samp(8'd100, ZI, 0, 1, 0, 8'd2);
    samp(8'd100, ZI, 0, 1, 0, 8'd2);
    samp(8'd100, ZI, 0, 0, 0, 8'd2);

    // PEND_HI cancelled by an INSIDE sample
    samp(8'd201, ZA, 0, 0, 0, 8'd2);
    samp(8'd201, ZA, 0, 0, 0, 8'd2);
    samp(8'd150, ZI, 0, 0, 0, 8'd2);
    samp(8'd201, ZA, 0, 0, 0, 8'd2);

    // Equality with a threshold is INSIDE and gives no debounce progress
    samp(8'd200, ZI, 0, 0, 0, 8'd2);
    samp(8'd201, ZA, 0, 0, 0, 8'd2);
    samp(8'd201, ZA, 0, 0, 0, 8'd2);
    samp(8'd200, ZI, 0, 0, 0, 8'd2);
    samp(8'd40,  ZI, 0, 0, 0, 8'd2);
    samp(8'd39,  ZB, 0, 0, 0, 8'd2);
    samp(8'd40,  ZI, 0, 0, 0, 8'd2);

    // Rejected load lo=90 hi=80; 85 still INSIDE proves 40/200 retained
    step(1'b1, 8'd80, 8'd90, 1'b0, 8'd0, 1'b0, ZI, 0, 0, 0, 8'd2, 1);
    idle(ZI, 0, 0, 8'd2);
    samp(8'd85, ZI, 0, 0, 0, 8'd2);
    samp(8'd200, ZI, 0, 0, 0, 8'd2);

    // Sample in the load cycle sees old thresholds; next one sees new (10/100)
    step(1'b1, 8'd100, 8'd10, 1'b1, 8'd150, 1'b0, ZI, 0, 0, 0, 8'd2, 0);
    samp(8'd150, ZA, 0, 0, 0, 8'd2);
    samp(8'd50,  ZI, 0, 0, 0, 8'd2);
    step(1'b1, 8'd200, 8'd40, 1'b0, 8'd0, 1'b0, ZI, 0, 0, 0, 8'd2, 0);

    // Qualifying samples separated by idle gaps still debounce
    samp(8'd201, ZA, 0, 0, 0, 8'd2);
    idle(ZA, 0, 0, 8'd2);
    samp(8'd201, ZA, 0, 0, 0, 8'd2);
    idle(ZA, 0, 0, 8'd2);
    idle(ZA, 0, 0, 8'd2);
    samp(8'd201, ZA, 1, 0, 1, 8'd3);
    idle(ZA, 1, 0, 8'd3);
    samp(8'd100, ZI, 1, 0, 0, 8'd3);
    idle(ZI, 1, 0, 8'd3);
    samp(8'd100, ZI, 1, 0, 0, 8'd3);
    samp(8'd201, ZA, 1, 0, 0, 8'd3);
    samp(8'd100, ZI, 1, 0, 0, 8'd3);
    samp(8'd100, ZI, 1, 0, 0, 8'd3);
    idle(ZI, 1, 0, 8'd3);
    samp(8'd100, ZI, 0, 0, 0, 8'd3);

    // Drive the counter to saturation and one entry beyond
    c = 3;
    for (int k = 0; k < 253; k++) begin
      samp(8'd201, ZA, 0, 0, 0, 8'(c));
      samp(8'd201, ZA, 0, 0, 0, 8'(c));
      c = (c == 255) ? 255 : c + 1;
      samp(8'd201, ZA, 1, 0, 1, 8'(c));
      samp(8'd100, ZI, 1, 0, 0, 8'(c));
      samp(8'd100, ZI, 1, 0, 0, 8'(c));
      samp(8'd100, ZI, 0, 0, 0, 8'(c));
    end

    // clr coinciding with an entry: count 0, pulse still asserted
    samp(8'd201, ZA, 0, 0, 0, 8'd255);
    samp(8'd201, ZA, 0, 0, 0, 8'd255);
    step(1'b0, 8'd0, 8'd0, 1'b1, 8'd201, 1'b1, ZA, 1, 0, 1, 8'd0, 0);
    samp(8'd100, ZI, 1, 0, 0, 8'd0);
    samp(8'd100, ZI, 1, 0, 0, 8'd0);
    samp(8'd100, ZI, 0, 0, 0, 8'd0);

    // Async reset while in PEND_HI with debounce count 2
    samp(8'd201, ZA, 0, 0, 0, 8'd0);
    samp(8'd201, ZA, 0, 0, 0, 8'd0);
    idle(ZA, 0, 0, 8'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", actual(), zero);
    @(negedge clk);
    rst_n = 1'b1;

    // Thresholds back to FF/00: extremes are INSIDE
    samp(8'd250, ZI, 0, 0, 0, 8'd0);
    samp(8'd255, ZI, 0, 0, 0, 8'd0);
    samp(8'd0,   ZI, 0, 0, 0, 8'd0);
    idle(ZI, 0, 0, 8'd0);

    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected records left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
